// File: rtl/spi_lcd_pkg.sv
// spi_lcd_pkg: shared FSM state encoding and parameter defaults for the SPI LCD master.
package spi_lcd_pkg;
   localparam int DATA_W_DEF  = 8;
   localparam int CLK_DIV_DEF = 2;
   localparam int MAX_RD_DEF  = 4;
   localparam int RST_CYC_DEF = 16;
   typedef enum logic [2:0] {RST_HOLD, IDLE, TX, RX, END} state_t;
endpackage

// File: rtl/spi_lcd_clkgen.sv
// spi_lcd_clkgen: mode-0 SCK divider; SCK idles low while disabled and the
// strobes flag the clk edge on which SCK is about to rise or fall.
module spi_lcd_clkgen
   import spi_lcd_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   output logic o_sck,
   output logic o_rise,
   output logic o_fall
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   logic [CW-1:0] r_cnt;
   logic          r_sck;
   logic          w_wrap;
   assign w_wrap = i_en && (r_cnt == CW'(CLK_DIV - 1));
   assign o_sck  = r_sck;
   assign o_rise = w_wrap && !r_sck;
   assign o_fall = w_wrap && r_sck;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_sck <= 1'b0;
      end else begin
         r_cnt <= (w_wrap || !i_en) ? '0 : r_cnt + 1'b1;
         r_sck <= i_en && (r_sck ^ w_wrap);
      end
   end
endmodule

// File: rtl/spi_lcd_master.sv
// spi_lcd_master: write-then-read SPI master for LCD panels with D/C line,
// panel reset sequencing and an optional read phase of up to MAX_RD bytes.
module spi_lcd_master
   import spi_lcd_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int CLK_DIV = CLK_DIV_DEF,
   parameter int MAX_RD  = MAX_RD_DEF,
   parameter int RST_CYC = RST_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              dc_in,
   input  logic [DATA_W-1:0] din,
   input  logic [3:0]        rd_len,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic              rd_valid,
   output logic [7:0]        rd_data,
   output logic              lcd_cs_n,
   output logic              lcd_dc,
   output logic              lcd_sck,
   output logic              lcd_mosi,
   input  logic              lcd_miso,
   output logic              lcd_rst_n
);
   localparam int HW = $clog2(RST_CYC + 1);
   state_t            r_state, w_next;
   logic [HW-1:0]     r_hold;
   logic [DATA_W-1:0] r_shift;
   logic              r_dc;
   logic [3:0]        r_left;
   logic [4:0]        r_bit;
   logic [7:0]        r_rx, r_rd_data;
   logic              r_rd_valid;
   logic              w_en, w_sck, w_rise, w_fall;
   logic [3:0]        w_len;
   assign w_len    = (rd_len > 4'(MAX_RD)) ? 4'(MAX_RD) : rd_len;
   assign lcd_dc   = r_dc;
   assign lcd_sck  = w_sck;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   spi_lcd_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_en),
      .o_sck (w_sck),
      .o_rise(w_rise),
      .o_fall(w_fall)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= RST_HOLD;
      else      r_state <= w_next;
   end
   always_comb begin
      w_next    = r_state;
      ready     = r_state == IDLE;
      busy      = r_state inside {TX, RX, END};
      done      = r_state == END;
      w_en      = r_state inside {TX, RX};
      lcd_cs_n  = !w_en;
      lcd_mosi  = (r_state == TX) && r_shift[DATA_W-1];
      lcd_rst_n = r_state != RST_HOLD;
      case (r_state)
         RST_HOLD: if (r_hold == HW'(RST_CYC - 1)) w_next = IDLE;
         IDLE:     if (start) w_next = TX;
         TX:       if (w_fall && r_bit == 5'(DATA_W - 1)) w_next = (r_left != 4'd0) ? RX : END;
         RX:       if (w_fall && r_bit == 5'd7 && r_left == 4'd1) w_next = END;
         END:      w_next = IDLE;
         default:  w_next = RST_HOLD;
      endcase
   end
   // Bit counter restarts at the TX->RX boundary so RX bytes align on r_bit==7.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold     <= '0;
         r_shift    <= '0;
         r_dc       <= 1'b0;
         r_left     <= '0;
         r_bit      <= '0;
         r_rx       <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         if (r_state == RST_HOLD) r_hold <= r_hold + 1'b1;
         if (r_state == IDLE && start) begin
            r_shift <= din;
            r_dc    <= dc_in;
            r_left  <= w_len;
            r_bit   <= '0;
         end
         if (r_state == TX && w_fall) begin
            r_shift <= r_shift << 1;
            r_bit   <= (r_bit == 5'(DATA_W - 1)) ? 5'd0 : r_bit + 5'd1;
         end
         if (r_state == RX && w_rise) begin
            r_rx <= {r_rx[6:0], lcd_miso};
            if (r_bit == 5'd7) begin
               r_rd_data  <= {r_rx[6:0], lcd_miso};
               r_rd_valid <= 1'b1;
            end
         end
         if (r_state == RX && w_fall) begin
            r_bit <= (r_bit == 5'd7) ? 5'd0 : r_bit + 5'd1;
            if (r_bit == 5'd7) r_left <= r_left - 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_spi_lcd_master.sv
// tb_spi_lcd_master: directed checks of the SPI LCD master (8-bit and 16-bit
// frames) against hand-computed cycle counts, bit patterns and read data.
module tb_spi_lcd_master;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start8 = 1'b0, dc8 = 1'b0, start16 = 1'b0, dc16 = 1'b0;
   logic [7:0] din8 = '0;
   logic [15:0] din16 = '0;
   logic [3:0] len8 = '0, len16 = '0;
   logic ready8, busy8, done8, rv8, cs8, dco8, sck8, mosi8, miso8, lrst8;
   logic ready16, busy16, done16, rv16, cs16, dco16, sck16, mosi16, lrst16;
   logic [7:0] rdd8, rdd16;
   logic miso16 = 1'b0;
   logic [31:0] miso_word = '0;
   int miso_base = 0;
   int n_assert = 0, n_fail = 0;
   int c_cs8 = 0, c_rise8 = 0, c_done8 = 0, c_rv8 = 0, c_cs16 = 0, c_rise16 = 0, c_done16 = 0;
   logic p_sck8 = 1'b0, p_sck16 = 1'b0, dcr8 = 1'b0, dcr16 = 1'b0;
   logic [31:0] sh8 = '0;
   logic [15:0] sh16 = '0;
   logic [7:0] rdq [16];
   int idx;
   int b_cs, b_rise, b_done, b_rv;

   always #5 clk = ~clk;

   spi_lcd_master u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .dc_in(dc8), .din(din8), .rd_len(len8),
      .ready(ready8), .busy(busy8), .done(done8), .rd_valid(rv8), .rd_data(rdd8),
      .lcd_cs_n(cs8), .lcd_dc(dco8), .lcd_sck(sck8), .lcd_mosi(mosi8),
      .lcd_miso(miso8), .lcd_rst_n(lrst8)
   );
   spi_lcd_master #(.DATA_W(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .dc_in(dc16), .din(din16), .rd_len(len16),
      .ready(ready16), .busy(busy16), .done(done16), .rd_valid(rv16), .rd_data(rdd16),
      .lcd_cs_n(cs16), .lcd_dc(dco16), .lcd_sck(sck16), .lcd_mosi(mosi16),
      .lcd_miso(miso16), .lcd_rst_n(lrst16)
   );

   // Slave model: RX bit j is presented once 8 command bits plus j read bits have clocked.
   assign idx   = c_rise8 - miso_base - 8;
   assign miso8 = (idx >= 0 && idx < 32) ? miso_word[31 - idx] : 1'b0;

   always @(posedge clk) begin
      p_sck8  <= sck8;
      p_sck16 <= sck16;
      if (!cs8) c_cs8 <= c_cs8 + 1;
      if (!cs16) c_cs16 <= c_cs16 + 1;
      if (done8) c_done8 <= c_done8 + 1;
      if (done16) c_done16 <= c_done16 + 1;
      if (sck8 && !p_sck8) begin
         c_rise8 <= c_rise8 + 1;
         sh8     <= {sh8[30:0], mosi8};
         dcr8    <= dco8;
      end
      if (sck16 && !p_sck16) begin
         c_rise16 <= c_rise16 + 1;
         sh16     <= {sh16[14:0], mosi16};
         dcr16    <= dco16;
      end
      if (rv8) begin
         rdq[c_rv8[3:0]] <= rdd8;
         c_rv8 <= c_rv8 + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_cs = c_cs8; b_rise = c_rise8; b_done = c_done8; b_rv = c_rv8;
   endtask

   task automatic go8(input logic [7:0] d, input logic dc, input logic [3:0] len);
      @(negedge clk);
      snap();
      miso_base = c_rise8;
      din8 = d; dc8 = dc; len8 = len; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_cs_n", cs8, 1);
      chk("rst_lcd_rst_n", lrst8, 0);
      chk("rst_sck", sck8, 0);
      chk("rst_mosi", mosi8, 0);
      chk("rst_dc", dco8, 0);
      chk("rst_ready", ready8, 0);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_rd_valid", rv8, 0);
      chk("rst_rd_data", rdd8, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      chk("hold_15", lrst8, 0);
      @(negedge clk);
      chk("hold_16_rst_n", lrst8, 1);
      chk("hold_16_ready", ready8, 1);

      // Write command 0x2C
      go8(8'h2C, 1'b0, 4'd0);
      chk("w_cs_first", cs8, 0);
      chk("w_busy_first", busy8, 1);
      chk("w_mosi_first", mosi8, 0);
      chk("w_ready_first", ready8, 0);
      repeat (32) @(negedge clk);
      chk("w_done", done8, 1);
      chk("w_end_cs", cs8, 1);
      chk("w_end_sck", sck8, 0);
      @(negedge clk);
      chk("w_ready", ready8, 1);
      chk("w_cs_len", c_cs8 - b_cs, 32);
      chk("w_rises", c_rise8 - b_rise, 8);
      chk("w_bits", sh8[7:0], 8'h2C);
      chk("w_dc", dcr8, 0);
      chk("w_done_cnt", c_done8 - b_done, 1);

      // Read ID: 0x04 then three bytes
      miso_word = 32'h5480_6600;
      go8(8'h04, 1'b0, 4'd3);
      repeat (128) @(negedge clk);
      chk("r_done", done8, 1);
      @(negedge clk);
      chk("r_ready", ready8, 1);
      chk("r_cs_len", c_cs8 - b_cs, 128);
      chk("r_rv_cnt", c_rv8 - b_rv, 3);
      chk("r_byte0", rdq[b_rv], 8'h54);
      chk("r_byte1", rdq[b_rv + 1], 8'h80);
      chk("r_byte2", rdq[b_rv + 2], 8'h66);
      chk("r_held", rdd8, 8'h66);
      chk("r_cmd_bits", sh8[31:24], 8'h04);

      // start pulsed while busy is ignored
      go8(8'hA5, 1'b1, 4'd0);
      repeat (10) @(negedge clk);
      chk("ign_busy", busy8, 1);
      din8 = 8'hFF; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (60) @(negedge clk);
      chk("ign_done_cnt", c_done8 - b_done, 1);
      chk("ign_cs_len", c_cs8 - b_cs, 32);
      chk("ign_bits", sh8[7:0], 8'hA5);
      chk("ign_dc", dcr8, 1);
      chk("ign_ready", ready8, 1);

      // rd_len=7 clamps to 4 bytes
      miso_word = 32'hC35A_0FF0;
      go8(8'hDA, 1'b0, 4'd7);
      repeat (160) @(negedge clk);
      chk("clamp_done", done8, 1);
      repeat (20) @(negedge clk);
      chk("clamp_rv_cnt", c_rv8 - b_rv, 4);
      chk("clamp_cs_len", c_cs8 - b_cs, 160);
      chk("clamp_byte3", rdd8, 8'hF0);

      // start held high: re-accepted on the IDLE cycle after END
      @(negedge clk);
      snap();
      din8 = 8'h3C; len8 = 4'd0; dc8 = 1'b0; start8 = 1'b1;
      repeat (34) @(negedge clk);
      chk("b2b_ready", ready8, 1);
      @(negedge clk);
      start8 = 1'b0;
      chk("b2b_cs", cs8, 0);
      repeat (33) @(negedge clk);
      chk("b2b_done_cnt", c_done8 - b_done, 2);
      chk("b2b_cs_len", c_cs8 - b_cs, 64);
      chk("b2b_ready2", ready8, 1);

      // reset mid-TX aborts
      go8(8'hFF, 1'b1, 4'd2);
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_cs", cs8, 1);
      chk("abort_rst_n", lrst8, 0);
      chk("abort_sck", sck8, 0);
      chk("abort_busy", busy8, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      chk("abort_hold_15", lrst8, 0);
      @(negedge clk);
      chk("abort_hold_16", lrst8, 1);
      chk("abort_no_done", c_done8 - b_done, 0);
      chk("abort_no_rv", c_rv8 - b_rv, 0);

      // 16-bit pixel frame
      @(negedge clk);
      b_cs = c_cs16; b_rise = c_rise16; b_done = c_done16;
      din16 = 16'hF81F; dc16 = 1'b1; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      chk("px_mosi_first", mosi16, 1);
      chk("px_dc", dco16, 1);
      repeat (65) @(negedge clk);
      chk("px_ready", ready16, 1);
      chk("px_cs_len", c_cs16 - b_cs, 64);
      chk("px_rises", c_rise16 - b_rise, 16);
      chk("px_bits", sh16, 16'hF81F);
      chk("px_dc_rise", dcr16, 1);
      chk("px_done_cnt", c_done16 - b_done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_lcd_master.md
SPI_LCD_MASTER -- requirements
Module: spi_lcd_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8, TX frame width in bits (legal values 8, 16, 24).
REQ-002 SHALL have parameter CLK_DIV, default 2, clk cycles per SCK half-period (>=1).
REQ-003 SHALL have parameter MAX_RD, default 4, maximum read bytes per transaction (1..15).
REQ-004 SHALL have parameter RST_CYC, default 16, clk cycles lcd_rst_n is held low after reset.
REQ-005 SHALL use one clock and an asynchronous active-low reset, with ports clk and rst.
REQ-006 Ports SHALL be as follows.
- clk  in  1  system clock
- rst  in  1  async active-low reset
- start  in  1  transaction request
- dc_in  in  1  D/C level for the TX frame (0=command, 1=data)
- din  in  DATA_W  TX frame, sent MSB first
- rd_len  in  4  read bytes following TX (0=write only)
- ready  out  1  high in IDLE only
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse at transaction end
- rd_valid  out  1  one-cycle pulse per received byte
- rd_data  out  8  received byte, valid with rd_valid, held afterwards
- lcd_cs_n  out  1  chip select, active low
- lcd_dc  out  1  D/C line
- lcd_sck  out  1  serial clock, mode 0, idles low
- lcd_mosi  out  1  serial out
- lcd_miso  in  1  serial in
- lcd_rst_n  out  1  panel reset, active low

Function
REQ-007 State machine SHALL have the states RST_HOLD, IDLE, TX, RX and END.
REQ-008 RST_HOLD SHALL drive lcd_rst_n=0 for RST_CYC cycles after reset release, then go to IDLE and set lcd_rst_n=1.
REQ-009 In IDLE, start=1 SHALL be accepted and din, dc_in and min(rd_len, MAX_RD) latched; start outside IDLE SHALL be ignored.
REQ-010 In the cycle after acceptance, the block SHALL drive lcd_cs_n=0, lcd_dc=latched dc_in, lcd_mosi=din[DATA_W-1] and busy=1.
REQ-011 Each bit SHALL occupy 2*CLK_DIV cycles: CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
REQ-012 MOSI SHALL change only while SCK is low; MISO SHALL be sampled on the clk where SCK rises.
REQ-013 SCK SHALL be generated from a divider register and SHALL never be gated from clk.
REQ-014 After DATA_W bits, the block SHALL enter RX if the latched rd_len is nonzero, else END; CS SHALL remain low across the TX to RX boundary.
REQ-015 In RX, lcd_mosi SHALL be 0; after every 8th sample, rd_data SHALL be updated and rd_valid pulsed in the following cycle.
REQ-016 END SHALL last one cycle with lcd_cs_n=1, SCK=0 and done=1, then go to IDLE.
REQ-017 Transaction length SHALL be 2 + (DATA_W + 8*rd_len)*2*CLK_DIV cycles from acceptance to ready=1.
REQ-018 rd_len greater than MAX_RD SHALL be clamped to MAX_RD.
REQ-019 Back-to-back operation: start held high SHALL be accepted on the IDLE cycle following END.

Reset
REQ-020 On rst=0, outputs SHALL immediately become: lcd_cs_n=1, lcd_rst_n=0, lcd_sck=0, lcd_mosi=0, lcd_dc=0, ready=0, busy=0, done=0, rd_valid=0, rd_data=0, and the state SHALL be RST_HOLD.
REQ-021 Reset during TX or RX SHALL abort the transaction with no done or rd_valid pulse.

Structure
REQ-022 Package spi_lcd_pkg SHALL hold the state enum and the parameter defaults.
REQ-023 Sub-module spi_lcd_clkgen SHALL produce the SCK level plus one-cycle rise and fall strobes from CLK_DIV.

Verification (DATA_W=8, CLK_DIV=2, MAX_RD=4)
REQ-024 Write command 0x2C, rd_len=0 -> MOSI bits 00101100, CS low for 32 cycles, 8 SCK rises, dc=0, a single done pulse.
REQ-025 Read ID 0x04, rd_len=3, MISO driving 0x54, 0x80, 0x66 -> three rd_valid pulses carrying those values, CS low for 128 cycles, then done.
REQ-026 start pulsed during busy -> ignored, with no second transaction.
REQ-027 rd_len=7 -> exactly 4 rd_valid pulses.
REQ-028 rst asserted mid-TX -> CS high and rst_n low immediately; lcd_rst_n low for 16 cycles after release; no done pulse.
REQ-029 DATA_W=16, pixel 0xF81F, dc=1 -> 16 bits MSB first, CS low for 64 cycles.
